fix_packer: RTL and testbench

- Transmit-side counterpart of the FIFO-to-byte unpacker: accepts a tagged byte stream and packs it into 64-bit words.
- Writes each message to the outbound word FIFO as one header word followed by the payload words.
- Buffers a complete message internally, because the header carries the word count and must precede the payload.
- Sits between the message-builder byte stream and the outbound FIFO write port.

---
 rtl/fix_pkt_pkg.sv | 33 +++
 rtl/fix_pack_buf.sv | 31 +++
 rtl/fix_packer.sv | 159 +++++++++++++++
 tb/tb_fix_packer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkt_pkg.sv
// Shared definitions for the FIX message packer: header field layout, FSM states
// and the header word builder.
package fix_pkt_pkg;

  localparam int ID_LSB    = 0;
  localparam int ID_W      = 2;
  localparam int LEN_LSB   = 4;
  localparam int LEN_W     = 15;
  localparam int LASTB_LSB = 20;
  localparam int LASTB_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HDR,
    DRAIN
  } fix_state_e;

  // LEN counts the header itself; a last-word byte count of 0 means a full word.
  function automatic logic [63:0] fix_build_hdr(
    input logic [ID_W-1:0]    id,
    input logic [LEN_W-1:0]   len,
    input logic [LASTB_W-1:0] lastb
  );
    logic [63:0] h;
    h = '0;
    h[ID_LSB +: ID_W]       = id;
    h[LEN_LSB +: LEN_W]     = len;
    h[LASTB_LSB +: LASTB_W] = lastb;
    return h;
  endfunction

endpackage

// File: rtl/fix_pack_buf.sv
// Payload word buffer: byte-lane write port, registered read port that only
// updates when rd_en_i is high, so a stalled reader sees a stable word.
module fix_pack_buf #(
  parameter int MAX_WORDS = 64,
  parameter int AW        = 6
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_be_i,
  input  logic [63:0]   wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [63:0]   rd_data_o
);

  logic [63:0] mem_q [MAX_WORDS];
  logic [63:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int l = 0; l < 8; l++) begin
        if (wr_be_i[l]) mem_q[wr_addr_i][8*l +: 8] <= wr_data_i[8*l +: 8];
      end
    end
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fix_packer.sv
// Packs a tagged byte stream into 64-bit words and writes each message to the
// outbound FIFO as a header word (id, LEN, last-word byte count) then payload.
//   state | meaning
//   IDLE  | waiting for a sop byte, ready_o high
//   FILL  | collecting payload bytes into the buffer, ready_o high
//   HDR   | header word on data_o, written when full_i is low
//   DRAIN | payload words written back to back while full_i is low
module fix_packer
  import fix_pkt_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int AW        = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        sop_i,
  input  logic        eop_i,
  input  logic [7:0]  data_i,
  input  logic [1:0]  id_i,
  output logic        ready_o,
  input  logic        full_i,
  output logic        writereq_o,
  output logic [63:0] data_o,
  output logic        error_o
);

  localparam int BCW = AW + 4;
  localparam logic [BCW-1:0] MAX_BYTES = BCW'(MAX_WORDS * 8);

  fix_state_e state_q, state_d;

  logic [BCW-1:0] cnt_q;
  logic [1:0]     id_q;
  logic [AW:0]    left_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [63:0]    data_q;
  logic           out_sel_q;
  logic           ready_q;
  logic           error_q;

  logic           acc;
  logic           start;
  logic           ovf;
  logic           byte_wr;
  logic           fin;
  logic           wr_req;
  logic           rd_en;
  logic           ready_d;
  logic           error_d;
  logic [BCW-1:0] pos;
  logic [BCW-1:0] cnt_nxt;
  logic [AW:0]    nwords;
  logic [1:0]     id_nxt;
  logic [2:0]     lane;
  logic [7:0]     wr_be;
  logic [63:0]    wr_data;
  logic [AW-1:0]  wr_addr;
  logic [63:0]    buf_rd;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (acc && sop_i) state_d = eop_i ? HDR : FILL;
      end
      FILL: begin
        if (acc) begin
          if (sop_i)      state_d = eop_i ? HDR : FILL;
          else if (ovf)   state_d = IDLE;
          else if (eop_i) state_d = HDR;
        end
      end
      HDR: begin
        if (!full_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!full_i && left_q == (AW+1)'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc     = valid_i && ready_q;
    start   = acc && sop_i;
    ovf     = (cnt_q == MAX_BYTES);
    byte_wr = start || (acc && (state_q == FILL) && !ovf);
    fin     = byte_wr && eop_i;
    error_d = acc && (state_q == FILL) && (sop_i || ovf);
    pos     = start ? '0 : cnt_q;
    cnt_nxt = pos + BCW'(1);
    nwords  = (AW+1)'((cnt_nxt + BCW'(7)) >> 3);
    id_nxt  = start ? id_i : id_q;
    lane    = pos[2:0];
    wr_addr = pos[AW+2:3];
    // Lane 0 opens a word: clear the other lanes so a short final word is zero-padded.
    wr_be   = (lane == 3'd0) ? 8'hFF : (8'b1 << lane);
    wr_data = (lane == 3'd0) ? {56'b0, data_i} : {8{data_i}};
    wr_req  = ((state_q == HDR) || (state_q == DRAIN)) && !full_i;
    rd_en   = wr_req && ((state_q == HDR) || (left_q != (AW+1)'(1)));
    ready_d = (state_d == IDLE) || (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      id_q      <= '0;
      left_q    <= '0;
      rd_ptr_q  <= '0;
      data_q    <= '0;
      out_sel_q <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      error_q <= error_d;
      if (byte_wr) begin
        cnt_q <= cnt_nxt;
        id_q  <= id_nxt;
      end
      if (fin) begin
        data_q    <= fix_build_hdr(id_nxt, LEN_W'(nwords) + LEN_W'(1), cnt_nxt[2:0]);
        out_sel_q <= 1'b0;
        left_q    <= nwords;
        rd_ptr_q  <= '0;
      end
      // Word 0 is fetched while the header is written, so payload follows without a gap.
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_req && (state_q == HDR))   out_sel_q <= 1'b1;
      if (wr_req && (state_q == DRAIN)) left_q    <= left_q - (AW+1)'(1);
    end
  end

  fix_pack_buf #(
    .MAX_WORDS(MAX_WORDS),
    .AW       (AW)
  ) u_buf (
    .clk      (clk),
    .wr_en_i  (byte_wr),
    .wr_addr_i(wr_addr),
    .wr_be_i  (wr_be),
    .wr_data_i(wr_data),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(buf_rd)
  );

  assign ready_o    = ready_q;
  assign error_o    = error_q;
  assign writereq_o = wr_req;
  assign data_o     = out_sel_q ? buf_rd : data_q;

endmodule

// File: tb/tb_fix_packer.sv
// Scoreboard bench for fix_packer: each message's expected header and payload
// words are queued when sent and popped as the DUT writes them.
module tb_fix_packer;

  localparam int MAX_WORDS = 64;
  localparam int AW        = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, sop_i, eop_i, full_i;
  logic [7:0]  data_i;
  logic [1:0]  id_i;
  logic        ready_o, writereq_o, error_o;
  logic [63:0] data_o;

  fix_packer #(.MAX_WORDS(MAX_WORDS), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .sop_i     (sop_i),
    .eop_i     (eop_i),
    .data_i    (data_i),
    .id_i      (id_i),
    .ready_o   (ready_o),
    .full_i    (full_i),
    .writereq_o(writereq_o),
    .data_o    (data_o),
    .error_o   (error_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_cnt = 0;
  int          err_cnt = 0;
  logic        chk_hold = 1'b0;
  logic [63:0] sb_q[$];
  logic [7:0]  msg_b[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (error_o) err_cnt++;
    if (chk_hold && full_i && sb_q.size() > 0) chk("stall_hold", data_o, sb_q[0]);
    if (writereq_o) begin
      wr_cnt++;
      chk("wr_when_full", full_i, 0);
      chk("wr_expected", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) chk("wr_data", data_o, sb_q.pop_front());
    end
  end

  task automatic fill_seq(input int n, input int start, input int step);
    msg_b.delete();
    for (int i = 0; i < n; i++) msg_b.push_back(8'(start + i * step));
  endtask

  task automatic model_push(input logic [1:0] id);
    int n, nw;
    logic [63:0] w;
    n  = msg_b.size();
    nw = (n + 7) / 8;
    w = '0;
    w[1:0]   = id;
    w[18:4]  = 15'(nw + 1);
    w[22:20] = 3'(n % 8);
    sb_q.push_back(w);
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int b = 0; b < 8; b++)
        if (8 * k + b < n) w[8*b +: 8] = msg_b[8*k + b];
      sb_q.push_back(w);
    end
  endtask

  task automatic send_byte(input logic s, input logic e, input logic [7:0] d, input logic [1:0] id);
    logic r;
    logic done;
    valid_i = 1'b1; sop_i = s; eop_i = e; data_i = d; id_i = id;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      r = ready_o;
      @(posedge clk);
      #1;
      if (r) done = 1'b1;
    end
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    if (!done) chk("accept_timeout", done, 1);
  endtask

  task automatic send_msg(input logic [1:0] id, input bit with_eop, input bit push);
    if (push) model_push(id);
    for (int i = 0; i < msg_b.size(); i++)
      send_byte(i == 0, with_eop && (i == msg_b.size() - 1), msg_b[i], id);
  endtask

  task automatic wait_drain(input int limit);
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    chk("drain_done", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, w0, lo;
    rst = 1'b1; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    data_i = '0; id_i = '0; full_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready_o, 0);
    chk("rst_wreq", writereq_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_err", error_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: short message, header latency and ready gap
    e0 = err_cnt;
    fill_seq(3, 'h11, 'h11);
    send_msg(2'd2, 1, 1);
    lo = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (t == 0) chk("t1_hdr_lat", writereq_o, 1);
      if (ready_o) break;
      lo++;
    end
    chk("t1_rdy_lo", lo, 2);
    @(posedge clk); #1;
    wait_drain(50);
    chk("t1_err", err_cnt - e0, 0);

    // 2: eop on lane 7, no padding word
    fill_seq(16, 'h00, 1);
    send_msg(2'd1, 1, 1);
    wait_drain(50);

    // 3: back-pressure after eop and toggling during drain
    fill_seq(9, 'h40, 3);
    full_i = 1'b1;
    w0 = wr_cnt;
    send_msg(2'd0, 1, 1);
    chk_hold = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t3_stall", writereq_o, 0);
      @(posedge clk); #1;
    end
    for (int t = 0; t < 60 && sb_q.size() > 0; t++) begin
      full_i = ~full_i;
      @(negedge clk);
      @(posedge clk); #1;
    end
    chk("t3_drained", sb_q.size(), 0);
    chk("t3_writes", wr_cnt - w0, 3);
    full_i = 1'b0;
    chk_hold = 1'b0;

    // 4: sop inside an open message
    e0 = err_cnt;
    fill_seq(5, 'hA0, 1);
    send_msg(2'd3, 0, 0);
    fill_seq(10, 'hC0, 1);
    send_msg(2'd1, 1, 1);
    wait_drain(50);
    chk("t4_err", err_cnt - e0, 1);

    // largest legal message
    e0 = err_cnt;
    fill_seq(MAX_WORDS * 8, 3, 7);
    send_msg(2'd1, 1, 1);
    wait_drain(200);
    chk("max_err", err_cnt - e0, 0);

    // 5: one byte too many, then a single-byte message
    e0 = err_cnt;
    w0 = wr_cnt;
    fill_seq(MAX_WORDS * 8 + 1, 0, 1);
    send_msg(2'd0, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_err", err_cnt - e0, 1);
    chk("t5_nowr", wr_cnt - w0, 0);
    fill_seq(1, 'h5A, 0);
    send_msg(2'd2, 1, 1);
    wait_drain(50);

    // 6: reset on the second drain cycle
    fill_seq(32, 'h80, 1);
    w0 = wr_cnt;
    send_msg(2'd3, 1, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_stop", writereq_o, 0);
    chk("t6_writes", wr_cnt - w0, 2);
    sb_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("t6_rdy_rst", ready_o, 0);
      chk("t6_wreq_rst", writereq_o, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rdy_after", ready_o, 1);
    @(posedge clk); #1;
    fill_seq(12, 'h31, 5);
    send_msg(2'd0, 1, 1);
    wait_drain(50);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
